// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, state encoding and request checks for lsu_master
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_CAPT,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  // Bus words carry the lowest-addressed byte in [31:24], so a full word is byte-reversed.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    byte_swap = {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic req_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = off[0];
      F3_W:    req_err = (off != 2'b00);
      F3_BU:   req_err = we;
      F3_HU:   req_err = we | off[0];
      default: req_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction/extension for loads and lane merge for stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] ld_word_i,
  input  logic [31:0] st_word_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0] b_lo;
  logic [7:0] b_hi;
  logic [1:0] off_hi;

  // Halfwords are 2-aligned, so the upper byte always sits at offset|1.
  assign off_hi = offset_i | 2'b01;

  always_comb begin
    b_lo = '0;
    b_hi = '0;
    for (int k = 0; k < 4; k++) begin
      if (offset_i == 2'(k)) b_lo = ld_word_i[31-8*k -: 8];
      if (off_hi == 2'(k))   b_hi = ld_word_i[31-8*k -: 8];
    end
    case (funct3_i)
      F3_B:    ld_data_o = {{24{b_lo[7]}}, b_lo};
      F3_BU:   ld_data_o = {24'b0, b_lo};
      F3_H:    ld_data_o = {{16{b_hi[7]}}, b_hi, b_lo};
      F3_HU:   ld_data_o = {16'b0, b_hi, b_lo};
      default: ld_data_o = byte_swap(ld_word_i);
    endcase
  end

  always_comb begin
    st_word_o = st_word_i;
    for (int k = 0; k < 4; k++) begin
      if (offset_i == 2'(k) && funct3_i != F3_W) st_word_o[31-8*k -: 8] = wdata_i[7:0];
      if (off_hi == 2'(k) && funct3_i == F3_H)   st_word_o[31-8*k -: 8] = wdata_i[15:8];
    end
    if (funct3_i == F3_W) st_word_o = byte_swap(wdata_i);
  end

endmodule

// File: rtl/lsu_master.sv
// rtl/lsu_master.sv - load/store unit bus master with read-modify-write for byte/halfword stores
module lsu_master
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        accept;
  logic        acc_err;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] wdata_q;
  logic [31:0] rword_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;
  logic [31:0] lsu_rdata_q;
  logic        lsu_done_q;
  logic        lsu_err_q;

  logic [2:0]  sel_f3;
  logic [1:0]  sel_off;
  logic [31:0] sel_wdata;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign acc_err = req_err(lsu_we, lsu_funct3, lsu_addr[1:0]);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lsu_req) begin
          accept = 1'b1;
          if (acc_err)                         state_d = ST_RESP;
          else if (lsu_we && lsu_funct3 == F3_W) state_d = ST_WR;
          else                                 state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_CAPT;
      ST_RD_CAPT:  state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:       state_d = ST_RESP;
      ST_RESP:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // SW goes straight from IDLE to WR, so the store word is built from the live request fields there.
  assign sel_f3    = (state_q == ST_IDLE) ? lsu_funct3     : f3_q;
  assign sel_off   = (state_q == ST_IDLE) ? lsu_addr[1:0]  : off_q;
  assign sel_wdata = (state_q == ST_IDLE) ? lsu_wdata      : wdata_q;

  lsu_align u_align (
    .funct3_i  (sel_f3),
    .offset_i  (sel_off),
    .wdata_i   (sel_wdata),
    .ld_word_i (rword_q),
    .st_word_i (mem_rdata),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      rword_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      lsu_rdata_q <= '0;
      lsu_done_q  <= 1'b0;
      lsu_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q    <= lsu_funct3;
        off_q   <= lsu_addr[1:0];
        we_q    <= lsu_we;
        err_q   <= acc_err;
        wdata_q <= lsu_wdata;
        if (!acc_err) mem_addr_q <= {lsu_addr[31:2], 2'b00};
      end
      if (state_q == ST_RD_CAPT) rword_q <= mem_rdata;
      mem_we_q <= (state_d == ST_WR);
      if (state_d == ST_WR) mem_wdata_q <= st_word;
      lsu_done_q <= (state_q == ST_RESP);
      lsu_err_q  <= (state_q == ST_RESP) && err_q;
      if (state_q == ST_RESP && !err_q && !we_q) lsu_rdata_q <= ld_data;
    end
  end

  assign lsu_busy  = (state_q != ST_IDLE);
  assign lsu_done  = lsu_done_q;
  assign lsu_err   = lsu_err_q;
  assign lsu_rdata = lsu_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: doc/lsu_master.md
LSU_MASTER -- requirements
Module: lsu_master

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 lsu_req  in  1  core request; sampled only in IDLE.
REQ-004 lsu_we  in  1  1=store, 0=load.
REQ-005 lsu_funct3  in  3  RISC-V width code: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
REQ-006 lsu_addr  in  32  byte address.
REQ-007 lsu_wdata  in  32  store data, little-endian; low bytes are used for SB/SH.
REQ-008 lsu_busy  out  1  high whenever state != IDLE.
REQ-009 lsu_done  out  1  one-cycle completion pulse.
REQ-010 lsu_err  out  1  misaligned address or illegal funct3; valid with lsu_done.
REQ-011 lsu_rdata  out  32  extended load result; holds its value until the next load completes.
REQ-012 mem_addr  out  32  word-aligned bus address, registered.
REQ-013 mem_wdata  out  32  bus write word, registered; mem_wdata[31:24] is byte at offset 0.
REQ-014 mem_we  out  1  bus write strobe, registered.
REQ-015 mem_rdata  in  32  responder data; valid in the cycle after the address is presented with mem_we=0; same byte order as mem_wdata.

Function
REQ-016 States SHALL be IDLE, RD_ISSUE, RD_CAPT, WR, RESP.
REQ-017 IDLE transitions on lsu_req=1:
- error -> RESP;
- load or SB/SH -> RD_ISSUE;
- SW -> WR.
REQ-018 Request fields SHALL be latched on acceptance; lsu_req outside IDLE (including RESP) SHALL be ignored.
REQ-019 Error conditions:
- LH/LHU/SH with addr[0]=1;
- LW/SW with addr[1:0]!=0;
- load funct3 in {3,6,7};
- store funct3 > 2.
REQ-020 An error request SHALL cause no bus activity: mem_addr and mem_we unchanged, lsu_rdata unchanged, lsu_err=1 in RESP.
REQ-021 mem_addr SHALL be {lsu_addr[31:2],2'b00} from the acceptance edge and held until the next acceptance.
REQ-022 Sequencing:
- RD_ISSUE -> RD_CAPT unconditionally;
- at the end of RD_CAPT, mem_rdata SHALL be captured;
- loads then go -> RESP, SB/SH go -> WR.
REQ-023 mem_we SHALL be 1 during exactly the single WR cycle and 0 in all other states; WR -> RESP.
REQ-024 RESP SHALL assert lsu_done for one cycle, then go -> IDLE.
REQ-025 Latency from acceptance edge to lsu_done high:
- load: 3 cycles;
- SW: 2 cycles;
- SB/SH: 4 cycles;
- error: 1 cycle.
REQ-026 Byte k (k = offset 0..3 within the word) SHALL be mem_rdata[31-8k -: 8]; LW result = {b3,b2,b1,b0}.
REQ-027 Load extension:
- LB/LH sign-extend and LBU/LHU zero-extend the byte or halfword at offset addr[1:0];
- the halfword low byte is at the lower address.
REQ-028 SW: mem_wdata = {wdata[7:0],wdata[15:8],wdata[23:16],wdata[31:24]}.
REQ-029 SB/SH: mem_wdata = captured word with lane(s) at the offset replaced by wdata[7:0] (and wdata[15:8] at offset+1); other lanes unchanged.

Reset
REQ-030 Asserting sys_rst_n low SHALL immediately force state=IDLE and clear mem_we, mem_addr, mem_wdata, lsu_rdata, lsu_done, lsu_err.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no later mem_we or lsu_done.
REQ-032 The first request after reset release SHALL be accepted on the first clock edge.

Structure
REQ-033 Package lsu_pkg SHALL hold the funct3 constants and state encoding.
REQ-034 Combinational sub-module lsu_align SHALL perform lane extraction and extension (REQ-026/027) and the store merge (REQ-028/029).

Verification
REQ-035 The bench SHALL use a responder model: byte RAM 0..127 where the byte at A maps to word bits [31:24], 1-cycle registered read.
REQ-036 SW 0x10, data 0x11223344 -> one mem_we cycle, mem_addr=0x10, mem_wdata=0x44332211; lsu_done 2 cycles after acceptance.
REQ-037 LW 0x10 -> lsu_rdata=0x11223344 after 3 cycles; LB 0x13 -> 0x00000011; LH 0x12 -> 0x00001122.
REQ-038 SB 0x12, data 0xFF -> read then write, mem_wdata=0x4433FF11; LB 0x12 -> 0xFFFFFFFF; LBU 0x12 -> 0x000000FF.
REQ-039 SH 0x12, data 0xABCD -> mem_wdata=0x4433CDAB; LW 0x10 -> 0xABCD3344; LHU 0x12 -> 0x0000ABCD.
REQ-040 LW 0x11 and LH 0x13 -> lsu_done+lsu_err 1 cycle after acceptance, mem_we never high, mem_addr unchanged.
REQ-041 SW 0xFFFFFF00, data 0xA5000000 -> mem_wdata=0x000000A5; responder byte 3 (LED) reads 0xA5.
REQ-042 Reset asserted during SB's RD_CAPT -> no mem_we, no lsu_done; the next request is serviced normally.
